ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one single-port RAM (wr/addr/wdata/rdata,
//  rdata valid only while wr=0) among NUM_REQ requesters, e.g. UART RX writer and host reader.
//  Accepts one request at a time via valid/ready, drives the RAM for exactly one cycle,
//  returns read data (or write ack) as a one-cycle response pulse. Sits between clients and RAM.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  ADDR_WIDTH  4   RAM address width
//  DATA_WIDTH  8   RAM data width
// PORTS
//  clk        in   1                    single clock, all logic on posedge
//  rst_l      in   1                    asynchronous, active-low reset
//  req_valid  in   NUM_REQ              per-requester request valid
//  req_wr     in   NUM_REQ              1=write, 0=read
//  req_addr   in   NUM_REQ*ADDR_WIDTH   packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata  in   NUM_REQ*DATA_WIDTH   packed, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  NUM_REQ              one-hot accept; request transfers when valid&ready
//  rsp_valid  out  NUM_REQ              one-hot one-cycle response pulse to owning requester
//  rsp_rdata  out  DATA_WIDTH           read data (0 for write responses), valid with rsp_valid
//  ram_wr     out  1                    to RAM wr
//  ram_addr   out  ADDR_WIDTH           to RAM addr
//  ram_wdata  out  DATA_WIDTH           to RAM wdata
//  ram_rdata  in   DATA_WIDTH           from RAM rdata (tri-stated by RAM during writes)
//  busy       out  1                    1 while in ACCESS state
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=NUM_REQ-1 (req 0 wins first), req_ready=0, rsp_valid=0,
//   rsp_rdata=0, ram_wr=0, ram_addr=0, ram_wdata=0, busy=0. Reset mid-ACCESS aborts; no response.
//  FSM states IDLE, ACCESS:
//   IDLE: req_ready combinational = one-hot pick among req_valid, searching from last_grant+1
//    with wrap to 0. If any valid: latch winner id, wr, addr, wdata; last_grant<=winner; ->ACCESS.
//    No valid: stay IDLE, req_ready=0.
//   ACCESS: ram_wr/addr/wdata driven from latched regs (registered outputs, no comb path from
//    req_*). Write commits at the closing edge. Read: ram_rdata sampled at closing edge into
//    rsp_rdata; write: rsp_rdata<=0 (never sample ram_rdata while ram_wr=1). -> IDLE.
//   rsp_valid[winner] high the cycle after ACCESS (first IDLE cycle), one cycle only.
//  Outside ACCESS: ram_wr=0, ram_addr=0, ram_wdata=0.
//  Latency: accept edge -> ACCESS 1 cycle -> rsp_valid next cycle; accept-to-response = 2 cycles.
//  Throughput: one transaction per 2 cycles; new accept may coincide with previous rsp_valid.
//  Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
//  Requester must hold valid/wr/addr/wdata stable until ready; dropping valid before ready
//   is legal (no grant). Same requester may re-request while its rsp_valid is high.
//  Simultaneous valids: only one req_ready bit per cycle; others see ready=0 and hold.
//  last_grant wraps NUM_REQ-1 -> 0; ids sized $clog2(NUM_REQ).
// STRUCTURE
//  Package ram_arb_pkg: state enum {IDLE, ACCESS}; function/localparam for id width.
//  Sub-module rr_pick (combinational): inputs req vector + last_grant, outputs one-hot grant
//   and encoded id; reusable by other shared-resource arbiters.
//  Bench instantiates ram_arbiter + RAM (ADDR_WIDTH=4, DATA_WIDTH=8).
// TESTING
//  1 Reset: rst_l=0 mid-ACCESS -> all outputs 0, busy=0, no rsp_valid; next grant goes to req 0.
//  2 Req0 write addr 3 <= 0xA5, then read addr 3 -> rsp_valid[0] 2 cycles after accept, rdata 0xA5.
//  3 Both valid every cycle (req0 wr, req1 rd) -> grants alternate 0,1,0,1; ram_wr=1 only in ACCESS.
//  4 Write response -> rsp_rdata=0x00 with rsp_valid pulse, never X/Z from tri-stated rdata.
//  5 NUM_REQ=3, req2 only valid after last_grant=2 -> wrap: req0 next, then req1, then req2.
//  6 Back-to-back: accept coincides with prior rsp_valid; addr 15 write/read boundary returns data.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter and its round-robin picker.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Requester ids never shrink below one bit, even for a two-way arbiter.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  int            idx_s;
  logic [ID_W-1:0] cand_s;

  // Scan every requester once, starting just after the previous winner.
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx_s   = 0;
    cand_s  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx_s = int'(last_i) + off;
      if (idx_s >= NUM_REQ) begin
        idx_s = idx_s - NUM_REQ;
      end else begin
        idx_s = idx_s;
      end
      cand_s = ID_W'(idx_s);
      if (!any_o && req_i[cand_s]) begin
        grant_o[cand_s] = 1'b1;
        id_o            = cand_s;
        any_o           = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer sharing one single-port RAM among NUM_REQ requesters;
// one RAM cycle per accepted request, response pulse on the following cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_wr,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic                          busy
);

  localparam int                 ID_W     = id_width(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_RST = ID_W'(NUM_REQ - 1);

  state_e                  state_q;
  logic [ID_W-1:0]         last_q;
  logic [ID_W-1:0]         id_q;
  logic                    ram_wr_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [DATA_WIDTH-1:0]   ram_wdata_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    busy_q;

  logic [NUM_REQ-1:0]      grant_s;
  logic [ID_W-1:0]         pick_id_s;
  logic                    any_s;
  logic                    win_wr_s;
  logic [ADDR_WIDTH-1:0]   win_addr_s;
  logic [DATA_WIDTH-1:0]   win_wdata_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (grant_s),
    .id_o    (pick_id_s),
    .any_o   (any_s)
  );

  assign win_wr_s    = req_wr[pick_id_s];
  assign win_addr_s  = req_addr[int'(pick_id_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata_s = req_wdata[int'(pick_id_s)*DATA_WIDTH +: DATA_WIDTH];

  // Ready is only offered while idle, so the winner's fields are latched exactly once.
  assign req_ready = (state_q == IDLE) ? grant_s : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

  // Two-state sequencer; RAM pins come straight from registers, never from req_*.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      id_q        <= '0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= '0;
          if (any_s) begin
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
            id_q        <= pick_id_s;
            last_q      <= pick_id_s;
            ram_wr_q    <= win_wr_s;
            ram_addr_q  <= win_addr_s;
            ram_wdata_q <= win_wdata_s;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ACCESS: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          ram_wr_q    <= 1'b0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          rsp_valid_q <= ONE_HOT0 << id_q;
          // The RAM floats its data bus during a write, so writes answer with zero.
          if (ram_wr_q) begin
            rsp_rdata_q <= '0;
          end else begin
            rsp_rdata_q <= ram_rdata;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          ram_wr_q    <= 1'b0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          rsp_valid_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with three requesters and a 16x8 RAM; a transaction-level
// model is compared every cycle, and hand-computed literals pin the scenarios.
module tb_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_l;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  wire  [N-1:0]    req_ready;
  wire  [N-1:0]    rsp_valid;
  wire  [DW-1:0]   rsp_rdata;
  wire             ram_wr;
  wire  [AW-1:0]   ram_addr;
  wire  [DW-1:0]   ram_wdata;
  wire  [DW-1:0]   ram_rdata;
  wire             busy;

  ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // Single-port RAM; during a write the bus carries junk standing in for a floating bus.
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_wr ? 8'hEE : mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int            g_id[$];
  int            g_cyc[$];
  int            r_id[$];
  int            r_cyc[$];
  logic [DW-1:0] r_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Transaction-level model state.
  logic [DW-1:0] shadow [16];
  int            m_last, m_busy, m_id, m_rspp, m_rsp_id;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rsp_data;

  task automatic model_reset();
    m_last = N - 1; m_busy = 0; m_id = 0; m_rspp = 0; m_rsp_id = 0;
    m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rsp_data = '0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: check outputs against the model each cycle, then advance the model.
  initial begin
    int p;
    logic [N-1:0] exp_ready;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_ram_wr",    32'(ram_wr),    32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        model_reset();
      end else begin
        p = pick(req_valid, m_last);
        exp_ready = (m_busy == 0 && p >= 0) ? N'(1) << p : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy",      32'(busy),      32'(m_busy));
        check("ram_wr",    32'(ram_wr),    (m_busy != 0) ? 32'(m_wr) : 32'd0);
        check("ram_addr",  32'(ram_addr),  (m_busy != 0) ? 32'(m_addr) : 32'd0);
        check("ram_wdata", 32'(ram_wdata), (m_busy != 0) ? 32'(m_wdata) : 32'd0);
        check("rsp_valid", 32'(rsp_valid), (m_rspp != 0) ? 32'(N'(1) << m_rsp_id) : 32'd0);
        check("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_data));
        if (req_ready != '0) begin
          g_id.push_back(oh2i(req_ready));
          g_cyc.push_back(cyc);
        end
        if (rsp_valid != '0) begin
          r_id.push_back(oh2i(rsp_valid));
          r_cyc.push_back(cyc);
          r_data.push_back(rsp_rdata);
        end
        if (m_busy != 0) begin
          m_rspp     = 1;
          m_rsp_id   = m_id;
          m_rsp_data = m_wr ? 8'h00 : shadow[m_addr];
          if (m_wr) shadow[m_addr] = m_wdata;
          m_busy = 0;
        end else begin
          m_rspp = 0;
          if (p >= 0) begin
            m_busy  = 1;
            m_id    = p;
            m_last  = p;
            m_wr    = req_wr[p];
            m_addr  = req_addr[p*AW +: AW];
            m_wdata = req_wdata[p*DW +: DW];
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i]            = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]         = 1'b1;
  endtask

  // Advance n cycles; with drop set, each requester lowers valid once it is accepted.
  task automatic run(input int n, input logic drop);
    logic [N-1:0] r;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      #1;
      if (drop) req_valid = req_valid & ~r;
    end
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete(); r_data.delete();
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      mem[a]    = '0;
      shadow[a] = '0;
    end
    model_reset();
    rst_l = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    run(2, 1'b0);

    // Write 0xA5 to addr 3, then read it back; write ack carries zero data.
    clear_logs();
    set_req(0, 1'b1, 4'd3, 8'hA5);
    run(4, 1'b1);
    set_req(0, 1'b0, 4'd3, 8'h00);
    run(4, 1'b1);
    check("t2_rsp_count", 32'(r_id.size()), 32'd2);
    check("t2_wack_data", 32'(r_data[0]), 32'h00);
    check("t2_rd_data",   32'(r_data[1]), 32'hA5);
    check("t2_rd_owner",  32'(r_id[1]), 32'd0);
    check("t2_latency",   32'(r_cyc[1] - g_cyc[1]), 32'd2);

    // Reset while a read is in its RAM cycle: no response may follow.
    clear_logs();
    set_req(1, 1'b0, 4'd3, 8'h00);
    run(1, 1'b1);
    rst_l = 1'b0;
    run(2, 1'b0);
    rst_l = 1'b1;
    run(3, 1'b0);
    check("t1_no_rsp_after_abort", 32'(r_id.size()), 32'd0);

    // Both requesters valid every cycle: grants alternate starting with req 0.
    clear_logs();
    set_req(0, 1'b1, 4'd5, 8'h3C);
    set_req(1, 1'b0, 4'd3, 8'h00);
    run(8, 1'b0);
    req_valid = '0;
    run(3, 1'b0);
    check("t3_grant0", 32'(g_id[0]), 32'd0);
    check("t3_grant1", 32'(g_id[1]), 32'd1);
    check("t3_grant2", 32'(g_id[2]), 32'd0);
    check("t3_grant3", 32'(g_id[3]), 32'd1);
    check("t3_rd_owner", 32'(r_id[1]), 32'd1);
    check("t3_rd_data",  32'(r_data[1]), 32'hA5);
    check("t3_b2b", 32'(g_cyc[1]), 32'(r_cyc[0]));

    // Wrap: after req 2 wins, all-valid must serve 0, then 1, then 2.
    clear_logs();
    set_req(2, 1'b0, 4'd5, 8'h00);
    run(4, 1'b1);
    set_req(0, 1'b0, 4'd3, 8'h00);
    set_req(1, 1'b0, 4'd5, 8'h00);
    set_req(2, 1'b0, 4'd15, 8'h00);
    run(6, 1'b1);
    run(3, 1'b0);
    check("t5_first",  32'(g_id[0]), 32'd2);
    check("t5_wrap0",  32'(g_id[1]), 32'd0);
    check("t5_wrap1",  32'(g_id[2]), 32'd1);
    check("t5_wrap2",  32'(g_id[3]), 32'd2);
    check("t5_rd5",    32'(r_data[0]), 32'h3C);

    // Back-to-back at the top address: read accept lands on the write's response cycle.
    clear_logs();
    set_req(0, 1'b1, 4'd15, 8'h5A);
    set_req(1, 1'b0, 4'd15, 8'h00);
    run(6, 1'b1);
    check("t6_order",     32'(g_id[1]), 32'd1);
    check("t6_b2b",       32'(g_cyc[1]), 32'(r_cyc[0]));
    check("t6_wack_data", 32'(r_data[0]), 32'h00);
    check("t6_rd15",      32'(r_data[1]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
